// File: rtl/gate_sensor.sv
// Two-beam gate sensor: synchronizes and debounces the a/b photo beams, then tracks
// the beam sequence to emit one incr per completed entry and one decr per completed exit.
module gate_sensor #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic a,
  input  logic b,
  output logic incr,
  output logic decr,
  output logic busy,
  output logic fault
);

  localparam int CW = $clog2(DEBOUNCE + 1);

  typedef enum logic [2:0] {IDLE, EN1, EN2, EN3, EX1, EX2, EX3, ERR} state_t;

  logic [SYNC_STAGES-1:0] a_sync_reg, b_sync_reg;
  logic [1:0]             pair;
  logic [1:0]             pair_prev_reg;
  logic [1:0]             filt_reg;
  logic [CW-1:0]          cnt_reg;
  logic                   filt_upd_reg;
  state_t                 state_reg, state_next;
  logic                   incr_next, decr_next;
  logic                   incr_reg, decr_reg, busy_reg, fault_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_sync_reg <= '0;
      b_sync_reg <= '0;
    end else begin
      a_sync_reg <= {a_sync_reg[SYNC_STAGES-2:0], a};
      b_sync_reg <= {b_sync_reg[SYNC_STAGES-2:0], b};
    end
  end

  assign pair = {a_sync_reg[SYNC_STAGES-1], b_sync_reg[SYNC_STAGES-1]};

  // cnt_reg holds how many consecutive edges pair has shown its current value
  // while differing from the filtered pair; acceptance strobes filt_upd_reg once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pair_prev_reg <= 2'b00;
      filt_reg      <= 2'b00;
      cnt_reg       <= '0;
      filt_upd_reg  <= 1'b0;
    end else begin
      pair_prev_reg <= pair;
      filt_upd_reg  <= 1'b0;
      if (pair == filt_reg) begin
        cnt_reg <= '0;
      end else if (pair != pair_prev_reg) begin
        cnt_reg <= CW'(1);
      end else if (cnt_reg == CW'(DEBOUNCE)) begin
        filt_reg     <= pair;
        filt_upd_reg <= 1'b1;
        cnt_reg      <= '0;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    incr_next  = 1'b0;
    decr_next  = 1'b0;
    if (filt_upd_reg) begin
      case (state_reg)
        IDLE: begin
          case (filt_reg)
            2'b10:   state_next = EN1;
            2'b01:   state_next = EX1;
            2'b11:   state_next = ERR;
            default: state_next = IDLE;
          endcase
        end
        EN1: begin
          case (filt_reg)
            2'b11:   state_next = EN2;
            2'b00:   state_next = IDLE;
            default: state_next = ERR;
          endcase
        end
        EN2: begin
          case (filt_reg)
            2'b01:   state_next = EN3;
            2'b10:   state_next = EN1;
            default: state_next = ERR;
          endcase
        end
        EN3: begin
          case (filt_reg)
            2'b00: begin
              state_next = IDLE;
              incr_next  = 1'b1;
            end
            2'b11:   state_next = EN2;
            default: state_next = ERR;
          endcase
        end
        EX1: begin
          case (filt_reg)
            2'b11:   state_next = EX2;
            2'b00:   state_next = IDLE;
            default: state_next = ERR;
          endcase
        end
        EX2: begin
          case (filt_reg)
            2'b10:   state_next = EX3;
            2'b01:   state_next = EX1;
            default: state_next = ERR;
          endcase
        end
        EX3: begin
          case (filt_reg)
            2'b00: begin
              state_next = IDLE;
              decr_next  = 1'b1;
            end
            2'b11:   state_next = EX2;
            default: state_next = ERR;
          endcase
        end
        default: begin
          if (filt_reg == 2'b00) state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      incr_reg  <= 1'b0;
      decr_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      fault_reg <= 1'b0;
    end else begin
      incr_reg  <= incr_next;
      decr_reg  <= decr_next;
      busy_reg  <= (state_reg != IDLE) && (state_reg != ERR);
      fault_reg <= (state_reg == ERR);
    end
  end

  assign incr  = incr_reg;
  assign decr  = decr_reg;
  assign busy  = busy_reg;
  assign fault = fault_reg;

endmodule

// File: tb/tb_gate_sensor.sv
// Bench for gate_sensor: scripted passages plus random beam traffic, every cycle
// checked against a path-position model of the filtered beam pair.
module tb_gate_sensor;

  localparam int S = 2;
  localparam int D = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic a = 1'b0;
  logic b = 1'b0;
  logic incr, decr, busy, fault;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  gate_sensor #(.SYNC_STAGES(S), .DEBOUNCE(D)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b),
    .incr(incr), .decr(decr), .busy(busy), .fault(fault)
  );

  // Reference model: raw samples go through an S-deep delay line; a value is
  // accepted once seen D+1 times in a row; passages are tracked as a direction
  // (1 entry, 2 exit, 3 error, 0 idle) and a position along the beam path.
  logic [1:0] dly_q[$];
  logic [1:0] run_val, m_filt, pend_val;
  int         run_len;
  bit         pend;
  int         m_dir, m_pos;
  int         m_incr, m_decr;

  int n_incr, n_decr, t_incr, t_decr;
  bit seen_busy, seen_fault;

  function automatic void model_reset();
    dly_q.delete();
    for (int i = 0; i < S; i++) dly_q.push_back(2'b00);
    run_val = 2'b00;
    run_len = D + 2;
    m_filt  = 2'b00;
    pend    = 1'b0;
    m_dir   = 0;
    m_pos   = 0;
  endfunction

  function automatic logic [1:0] path_elem(input int dir, input int idx);
    logic [7:0] seq;
    seq = (dir == 1) ? 8'b00_10_11_01 : 8'b00_01_11_10;
    return seq[7-2*idx -: 2];
  endfunction

  function automatic int fsm_apply(input logic [1:0] v);
    int ev = 0;
    if (m_dir == 0) begin
      if (v == 2'b10) begin m_dir = 1; m_pos = 1; end
      else if (v == 2'b01) begin m_dir = 2; m_pos = 1; end
      else if (v == 2'b11) m_dir = 3;
    end else if (m_dir == 3) begin
      if (v == 2'b00) m_dir = 0;
    end else if (v == path_elem(m_dir, (m_pos + 1) % 4)) begin
      if (m_pos == 3) begin ev = m_dir; m_dir = 0; end
      else m_pos++;
    end else if (v == path_elem(m_dir, m_pos - 1)) begin
      m_pos--;
      if (m_pos == 0) m_dir = 0;
    end else begin
      m_dir = 3;
    end
    return ev;
  endfunction

  task automatic clear_tallies();
    n_incr = 0; n_decr = 0; t_incr = -1; t_decr = -1;
    seen_busy = 1'b0; seen_fault = 1'b0;
  endtask

  task automatic step(input logic [1:0] ab);
    logic [1:0] p;
    int ev;
    bit busy_exp, fault_exp;
    a = ab[1];
    b = ab[0];
    @(posedge clk);
    cyc++;
    busy_exp  = (m_dir == 1) || (m_dir == 2);
    fault_exp = (m_dir == 3);
    ev = 0;
    if (pend) ev = fsm_apply(pend_val);
    pend = 1'b0;
    if (ev == 1) m_incr++;
    if (ev == 2) m_decr++;
    dly_q.push_back(ab);
    p = dly_q.pop_front();
    if (p == run_val) begin
      if (run_len < 1000) run_len++;
    end else begin
      run_val = p;
      run_len = 1;
    end
    if (run_len == D + 1 && p != m_filt) begin
      m_filt = p; pend = 1'b1; pend_val = p;
    end
    #1;
    checks += 4;
    if (incr !== (ev == 1)) begin
      errors++; $display("FAIL incr cyc=%0d got=%b exp=%b", cyc, incr, (ev == 1));
    end
    if (decr !== (ev == 2)) begin
      errors++; $display("FAIL decr cyc=%0d got=%b exp=%b", cyc, decr, (ev == 2));
    end
    if (busy !== busy_exp) begin
      errors++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, busy_exp);
    end
    if (fault !== fault_exp) begin
      errors++; $display("FAIL fault cyc=%0d got=%b exp=%b", cyc, fault, fault_exp);
    end
    if (incr === 1'b1) begin n_incr++; t_incr = cyc; $display("cyc %0d incr pulse", cyc); end
    if (decr === 1'b1) begin n_decr++; t_decr = cyc; $display("cyc %0d decr pulse", cyc); end
    if (busy === 1'b1) seen_busy = 1'b1;
    if (fault === 1'b1) seen_fault = 1'b1;
  endtask

  task automatic hold(input logic [1:0] ab, input int n);
    repeat (n) step(ab);
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++; $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i <= n; i++) begin
      if (i > 0) @(negedge clk);
      else #1;
      checks++;
      if ({incr, decr, busy, fault} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_outputs got=%b exp=0000", {incr, decr, busy, fault});
      end
    end
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    model_reset();
    clear_tallies();
    reset = 1'b0;
    do_reset(3);
    hold(2'b00, 4);
    $display("reset: done");
  endtask

  task automatic test_entry();
    int n_fin;
    clear_tallies();
    hold(2'b00, 8); hold(2'b10, 8); hold(2'b11, 8); hold(2'b01, 8);
    n_fin = cyc + 1;
    hold(2'b00, 16);
    check_int("entry_incr_count", n_incr, 1);
    check_int("entry_decr_count", n_decr, 0);
    check_int("entry_latency", t_incr, n_fin + S + D + 1);
    check_int("entry_busy_seen", int'(seen_busy), 1);
    $display("entry: incr=%0d decr=%0d", n_incr, n_decr);
  endtask

  task automatic test_exit();
    int n_fin;
    clear_tallies();
    hold(2'b00, 8); hold(2'b01, 8); hold(2'b11, 8); hold(2'b10, 8);
    n_fin = cyc + 1;
    hold(2'b00, 16);
    check_int("exit_decr_count", n_decr, 1);
    check_int("exit_incr_count", n_incr, 0);
    check_int("exit_latency", t_decr, n_fin + S + D + 1);
    $display("exit: incr=%0d decr=%0d", n_incr, n_decr);
  endtask

  task automatic test_glitch();
    clear_tallies();
    hold(2'b00, 8); hold(2'b10, 8); hold(2'b11, 4); hold(2'b01, 2);
    hold(2'b11, 6); hold(2'b01, 8); hold(2'b00, 16);
    check_int("glitch_incr_count", n_incr, 1);
    check_int("glitch_fault_seen", int'(seen_fault), 0);
    $display("glitch: incr=%0d", n_incr);
  endtask

  task automatic test_backout();
    clear_tallies();
    hold(2'b00, 8); hold(2'b10, 8); hold(2'b00, 16);
    check_int("backout_incr_count", n_incr, 0);
    clear_tallies();
    hold(2'b10, 8); hold(2'b11, 8); hold(2'b10, 8); hold(2'b11, 8);
    hold(2'b01, 8); hold(2'b00, 16);
    check_int("reversal_incr_count", n_incr, 1);
    $display("backout/reversal: incr=%0d", n_incr);
  endtask

  task automatic test_err();
    clear_tallies();
    hold(2'b00, 4); hold(2'b11, 12);
    check_int("err_fault_set", int'(fault), 1);
    hold(2'b11, 8); hold(2'b00, 12);
    check_int("err_fault_clear", int'(fault), 0);
    check_int("err_pulses", n_incr + n_decr, 0);
    hold(2'b01, 8); hold(2'b11, 8); hold(2'b10, 8); hold(2'b00, 16);
    check_int("err_then_exit_decr", n_decr, 1);
    $display("err: decr=%0d", n_decr);
  endtask

  task automatic test_reset_mid();
    clear_tallies();
    hold(2'b00, 4); hold(2'b10, 8); hold(2'b11, 8); hold(2'b01, 10);
    do_reset(3);
    hold(2'b00, 16);
    check_int("reset_mid_incr", n_incr, 0);
    $display("reset_mid: incr=%0d", n_incr);
  endtask

  task automatic test_back_to_back();
    clear_tallies();
    hold(2'b10, D + 1); hold(2'b11, D + 1); hold(2'b01, D + 1); hold(2'b00, D + 1);
    hold(2'b01, D + 1); hold(2'b11, D + 1); hold(2'b10, D + 1); hold(2'b00, 16);
    check_int("b2b_incr", n_incr, 1);
    check_int("b2b_decr", n_decr, 1);
    check_int("b2b_spacing", t_decr - t_incr, 4 * (D + 1));
    $display("back_to_back: incr=%0d decr=%0d", n_incr, n_decr);
  endtask

  task automatic test_random();
    logic [1:0] v;
    clear_tallies();
    m_incr = 0; m_decr = 0;
    for (int i = 0; i < 250; i++) begin
      v = 2'($urandom_range(0, 3));
      hold(v, int'($urandom_range(1, 9)));
    end
    hold(2'b00, 20);
    check_int("random_incr_total", n_incr, m_incr);
    check_int("random_decr_total", n_decr, m_decr);
    $display("random: incr=%0d decr=%0d", n_incr, n_decr);
  endtask

  initial begin
    test_reset();
    test_entry();
    test_exit();
    test_glitch();
    test_backout();
    test_err();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_sensor.md
GATE_SENSOR -- requirements
Module: gate_sensor

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer flops per sensor input, minimum 2.
REQ-002 Parameter DEBOUNCE, default 4: consecutive stable cycles required before a synchronized sensor pair is accepted, minimum 1.
REQ-003 Port clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 Port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 Port a  input  1  outer photo sensor, 1 = beam blocked, asynchronous to clk.
REQ-006 Port b  input  1  inner photo sensor, 1 = beam blocked, asynchronous to clk.
REQ-007 Port incr  output  1  one-cycle pulse per completed entry; drives car_counter incr.
REQ-008 Port decr  output  1  one-cycle pulse per completed exit; drives car_counter decr.
REQ-009 Port busy  output  1  high while a passage is in progress (any state except IDLE and ERR).
REQ-010 Port fault  output  1  high while in ERR state.

Function
REQ-011 a and b SHALL each pass through a SYNC_STAGES-deep flop chain before any other logic uses them.
REQ-012 Debounce: the filtered pair {af,bf} SHALL take a new synchronized value {as,bs} only after {as,bs} has differed from {af,bf} and held constant for DEBOUNCE consecutive cycles.
REQ-013 Any change in {as,bs} before DEBOUNCE cycles elapse SHALL restart the stability count; shorter glitches never reach the FSM.
REQ-014 The stability counter SHALL be ceil(log2(DEBOUNCE+1)) bits wide and SHALL saturate, never wrap.
REQ-015 FSM states: IDLE, EN1, EN2, EN3, EX1, EX2, EX3, ERR. Each transition is evaluated on the cycle {af,bf} changes; an unchanged {af,bf} holds the state.
REQ-016 IDLE: 10->EN1; 01->EX1; 11->ERR.
REQ-017 EN1: 11->EN2; 00->IDLE with no pulse (car backed out); 01->ERR.
REQ-018 EN2: 01->EN3; 10->EN1 (reversal); 00->ERR.
REQ-019 EN3: 00->IDLE and assert incr; 11->EN2; 10->ERR.
REQ-020 EX1: 11->EX2; 00->IDLE with no pulse; 10->ERR.
REQ-021 EX2: 10->EX3; 01->EX1; 00->ERR.
REQ-022 EX3: 00->IDLE and assert decr; 11->EX2; 01->ERR.
REQ-023 ERR: 00->IDLE; any other value holds ERR; no pulses are issued from ERR.
REQ-024 incr and decr SHALL be registered, high for exactly one cycle, and never high in the same cycle.
REQ-025 Latency: raw input reaching its final 00 at edge N, stable thereafter, SHALL produce incr/decr high for the single cycle following edge N+SYNC_STAGES+DEBOUNCE+1.
REQ-026 busy and fault SHALL be registered decodes of the state, valid one cycle after the state is entered.
REQ-027 Back-to-back passages SHALL be accepted with no dead cycles beyond the debounce requirement.

Reset
REQ-028 reset=0 SHALL asynchronously clear the synchronizer flops, the filtered pair (00), and the stability counter (0), and SHALL force state IDLE.
REQ-029 While reset=0 and on the first cycle after release: incr=0, decr=0, busy=0, fault=0.
REQ-030 A reset asserted mid-passage SHALL discard that passage with no pulse, either during reset or after release.

Verification
REQ-031 DEBOUNCE=4; drive ab 00->10->11->01->00, each held 8 cycles -> exactly one incr pulse, latency per REQ-025, decr stays 0, busy 1 during passage.
REQ-032 ab 00->01->11->10->00, each held 8 cycles -> exactly one decr pulse, incr stays 0.
REQ-033 Entry with a 2-cycle a=0 glitch inside the 11 phase -> glitch filtered, single incr, no fault.
REQ-034 ab 00->10->00, then 00->10->11->10->11->01->00 -> first sequence gives no pulse; second gives one incr.
REQ-035 ab 00->11 directly -> fault=1, no pulse; hold 11, then 00 -> fault=0, state IDLE; a following normal exit gives one decr.
REQ-036 Drop reset to 0 during EN3, release, then drive ab=00 -> no incr; outputs all 0 during and after reset.
